// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory-side blocks: default bus widths and the
// copy-engine state encoding.
package mem_copy_pkg;

  localparam int DEF_ADDR_W = 32'd8;
  localparam int DEF_DATA_W = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } mc_state_t;

endpackage

// File: rtl/mem_copy_master.sv
// Byte-wise forward memory copy engine: one read cycle then one write cycle per
// byte, with abort and a one-cycle done pulse.
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bytes_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  mc_state_t         state_r, state_s;
  logic [ADDR_W-1:0] src_r, src_s;
  logic [ADDR_W-1:0] dst_r, dst_s;
  logic [ADDR_W-1:0] len_r, len_s;
  logic [ADDR_W-1:0] index_r, index_s;
  logic [ADDR_W-1:0] bytes_r, bytes_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic [ADDR_W-1:0] index_inc_s;

  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              write_r, write_s;
  logic              read_r, read_s;

  assign index_inc_s = index_r + ADDR_W'(1'b1);

  // Next-state and datapath update logic.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    len_s   = len_r;
    index_s = index_r;
    bytes_s = bytes_r;
    data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          src_s   = src_addr;
          dst_s   = dst_addr;
          len_s   = length;
          index_s = {ADDR_W{1'b0}};
          bytes_s = {ADDR_W{1'b0}};
          if (length != {ADDR_W{1'b0}}) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_FINISH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        data_s = mem_read_data;
        if (abort) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_WRITE: begin
        index_s = index_inc_s;
        bytes_s = bytes_r + ADDR_W'(1'b1);
        if (abort || (index_inc_s == len_r)) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_s == ST_FINISH);
    addr_s  = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    write_s = 1'b0;
    read_s  = 1'b0;
    case (state_s)
      ST_READ: begin
        addr_s = ADDR_W'(src_s + index_s);
        read_s = 1'b1;
      end
      ST_WRITE: begin
        addr_s  = ADDR_W'(dst_s + index_s);
        wdata_s = data_s;
        write_s = 1'b1;
      end
      default: begin
        addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      src_r   <= {ADDR_W{1'b0}};
      dst_r   <= {ADDR_W{1'b0}};
      len_r   <= {ADDR_W{1'b0}};
      index_r <= {ADDR_W{1'b0}};
      bytes_r <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      write_r <= 1'b0;
      read_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      len_r   <= len_s;
      index_r <= index_s;
      bytes_r <= bytes_s;
      data_r  <= data_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      write_r <= write_s;
      read_r  <= read_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign bytes_done     = bytes_r;
  assign mem_address    = addr_r;
  assign mem_write_data = wdata_r;
  assign mem_write      = write_r;
  assign mem_read       = read_r;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a behavioural byte memory.
module tb_mem_copy_master;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       busy;
  logic       done;
  logic [7:0] bytes_done;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_read_data;

  logic [7:0] mem [0:255];
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [7:0] poke_data;
  logic [7:0] rd_log [$];
  logic [7:0] wr_log [$];

  int n_checks;
  int n_fail;

  mem_copy_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .bytes_done(bytes_done),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_read) rd_log.push_back(mem_address);
    if (mem_write) begin
      mem[mem_address] <= mem_write_data;
      wr_log.push_back(mem_address);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Drives start across one edge; returns at the negedge of cycle 1.
  task automatic do_start(input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic ab);
    src_addr = s; dst_addr = d; length = l; abort = ab; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bytes_done, mem_address, mem_write_data, mem_write, mem_read} !== 29'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {busy, done, bytes_done, mem_address, mem_write_data, mem_write, mem_read});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic_copy();
    int done_cyc;
    int wbase;
    poke(8'h0A, 8'h05); poke(8'h0B, 8'h03); poke(8'h0C, 8'h07);
    wbase = wr_log.size();
    do_start(8'h0A, 8'h20, 8'd3, 1'b0);
    n_checks++;
    if ({busy, mem_read, mem_address} !== {1'b1, 1'b1, 8'h0A}) begin
      n_fail++; $display("FAIL basic_first_read: busy/rd/addr %h expected 30a", {busy, mem_read, mem_address});
    end
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    n_checks++;
    if (done_cyc != 7) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc);
    end
    @(negedge clk);
    n_checks++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== 24'h050307) begin
      n_fail++; $display("FAIL basic_data: got %h expected 050307", {mem[8'h20], mem[8'h21], mem[8'h22]});
    end
    n_checks++;
    if ({busy, done, bytes_done} !== {2'b00, 8'd3}) begin
      n_fail++; $display("FAIL basic_bytes_done: got %h expected 003", {busy, done, bytes_done});
    end
    n_checks++;
    if (wr_log.size() - wbase != 3) begin
      n_fail++; $display("FAIL basic_write_count: got %0d expected 3", wr_log.size() - wbase);
    end
  endtask

  task automatic test_zero_length();
    int done_cyc;
    int rbase;
    int wbase;
    rbase = rd_log.size(); wbase = wr_log.size();
    do_start(8'h10, 8'h30, 8'd0, 1'b0);
    done_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    n_checks++;
    if (done_cyc != 1) begin
      n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc);
    end
    n_checks++;
    if ({mem_address, mem_write_data} !== 16'h0000) begin
      n_fail++; $display("FAIL zero_finish_bus: got %h expected 0000", {mem_address, mem_write_data});
    end
    @(negedge clk);
    n_checks++;
    if ((rd_log.size() - rbase) + (wr_log.size() - wbase) != 0 || bytes_done !== 8'd0) begin
      n_fail++; $display("FAIL zero_no_access: accesses %0d bytes_done %0d expected 0 0",
        (rd_log.size() - rbase) + (wr_log.size() - wbase), bytes_done);
    end
  endtask

  task automatic test_wrap();
    int done_cyc;
    int rbase;
    int wbase;
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    rbase = rd_log.size(); wbase = wr_log.size();
    do_start(8'hFE, 8'h40, 8'd3, 1'b0);
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (rd_log.size() - rbase != 3 || wr_log.size() - wbase != 3) begin
      n_fail++; $display("FAIL wrap_counts: reads %0d writes %0d expected 3 3",
        rd_log.size() - rbase, wr_log.size() - wbase);
    end else begin
      n_checks++;
      if ({rd_log[rbase], rd_log[rbase+1], rd_log[rbase+2]} !== 24'hFEFF00) begin
        n_fail++; $display("FAIL wrap_read_addr: got %h expected feff00",
          {rd_log[rbase], rd_log[rbase+1], rd_log[rbase+2]});
      end
      n_checks++;
      if ({wr_log[wbase], wr_log[wbase+1], wr_log[wbase+2]} !== 24'h404142) begin
        n_fail++; $display("FAIL wrap_write_addr: got %h expected 404142",
          {wr_log[wbase], wr_log[wbase+1], wr_log[wbase+2]});
      end
    end
    n_checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== 24'h112233) begin
      n_fail++; $display("FAIL wrap_data: got %h expected 112233", {mem[8'h40], mem[8'h41], mem[8'h42]});
    end
  endtask

  task automatic test_start_ignored();
    int done_cyc;
    int wbase;
    wbase = wr_log.size();
    do_start(8'h0A, 8'h30, 8'd3, 1'b0);
    @(negedge clk);
    src_addr = 8'h50; dst_addr = 8'h70; length = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0;
    for (int c = 3; c <= 40 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    n_checks++;
    if (done_cyc != 7) begin
      n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 7", done_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (wr_log.size() - wbase != 3 || {mem[8'h30], mem[8'h31], mem[8'h32]} !== 24'h050307) begin
      n_fail++; $display("FAIL ignore_result: writes %0d data %h expected 3 050307",
        wr_log.size() - wbase, {mem[8'h30], mem[8'h31], mem[8'h32]});
    end
  endtask

  task automatic test_overlap();
    int done_cyc;
    poke(8'h60, 8'hA1); poke(8'h61, 8'hB2); poke(8'h62, 8'hC3); poke(8'h63, 8'hD4);
    do_start(8'h60, 8'h61, 8'd3, 1'b0);
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if ({mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]} !== 32'hA1A1A1A1) begin
      n_fail++; $display("FAIL overlap_forward: got %h expected a1a1a1a1",
        {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]});
    end
  endtask

  task automatic test_abort();
    int done_cyc;
    int wbase;
    poke(8'h80, 8'h01); poke(8'h81, 8'h02); poke(8'h82, 8'h03);
    poke(8'h83, 8'h04); poke(8'h84, 8'h05);
    poke(8'h90, 8'hEE); poke(8'h91, 8'hEE); poke(8'h92, 8'hEE);
    wbase = wr_log.size();
    do_start(8'h80, 8'h90, 8'd5, 1'b0);
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      abort = (c == 4);
      if (c == 4) begin
        n_checks++;
        if ({mem_write, mem_address} !== {1'b1, 8'h91}) begin
          n_fail++; $display("FAIL abort_second_write: wr/addr %h expected 191", {mem_write, mem_address});
        end
      end
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    abort = 1'b0;
    n_checks++;
    if (done_cyc != 5) begin
      n_fail++; $display("FAIL abort_done_cycle: got %0d expected 5", done_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (wr_log.size() - wbase != 2 || bytes_done !== 8'd2) begin
      n_fail++; $display("FAIL abort_count: writes %0d bytes_done %0d expected 2 2",
        wr_log.size() - wbase, bytes_done);
    end
    n_checks++;
    if ({mem[8'h90], mem[8'h91], mem[8'h92]} !== 24'h0102EE) begin
      n_fail++; $display("FAIL abort_data: got %h expected 0102ee", {mem[8'h90], mem[8'h91], mem[8'h92]});
    end
  endtask

  task automatic test_start_with_abort();
    int done_cyc;
    int wbase;
    wbase = wr_log.size();
    do_start(8'h0B, 8'hA0, 8'd1, 1'b1);
    done_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      if (done === 1'b1) done_cyc = c; else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (done_cyc != 3 || wr_log.size() - wbase != 1 || mem[8'hA0] !== 8'h03) begin
      n_fail++; $display("FAIL start_abort_idle: done cyc %0d writes %0d data %h expected 3 1 03",
        done_cyc, wr_log.size() - wbase, mem[8'hA0]);
    end
  endtask

  task automatic test_reset_mid_copy();
    int wbase;
    int saw_done;
    poke(8'hC0, 8'h01); poke(8'hC1, 8'h02); poke(8'hC2, 8'h03); poke(8'hC3, 8'h04);
    poke(8'hD0, 8'hEE); poke(8'hD1, 8'hEE); poke(8'hD2, 8'hEE); poke(8'hD3, 8'hEE);
    wbase = wr_log.size();
    do_start(8'hC0, 8'hD0, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_write, mem_address} !== {1'b1, 8'hD1}) begin
      n_fail++; $display("FAIL rst_pre_write: wr/addr %h expected 1d1", {mem_write, mem_address});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bytes_done, mem_address, mem_write_data, mem_write, mem_read} !== 29'd0) begin
      n_fail++; $display("FAIL rst_async_outputs: got %h expected 0",
        {busy, done, bytes_done, mem_address, mem_write_data, mem_write, mem_read});
    end
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done != 0 || wr_log.size() - wbase != 1) begin
      n_fail++; $display("FAIL rst_no_done_writes: done %0d writes %0d expected 0 1",
        saw_done, wr_log.size() - wbase);
    end
    n_checks++;
    if ({mem[8'hD0], mem[8'hD1], mem[8'hD2], mem[8'hD3]} !== 32'h01EEEEEE) begin
      n_fail++; $display("FAIL rst_dst_untouched: got %h expected 01eeeeee",
        {mem[8'hD0], mem[8'hD1], mem[8'hD2], mem[8'hD3]});
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00;
    poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_start_ignored();
    test_overlap();
    test_abort();
    test_start_with_abort();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
